// File: rtl/clip_cull_pkg.sv
// ----------------------------------------------------------------------------
// clip_cull_pkg
// Shared types, constants and helpers for the clip/cull stage.
//   Points2D   : one signed 16-bit coordinate
//   Vertex3D   : x/y/z coordinate triple
//   Triangle3D : p/q/r vertices (the primitive carried through the stage)
//   CNT_W_DEFAULT : default width of the debug cull counter
//   XMIN..ZMAX : inclusive clip volume bounds, compared as signed values
// ----------------------------------------------------------------------------
package clip_cull_pkg;

    typedef logic signed [15:0] Points2D;

    typedef struct packed {
        Points2D x;
        Points2D y;
        Points2D z;
    } Vertex3D;

    typedef struct packed {
        Vertex3D p;
        Vertex3D q;
        Vertex3D r;
    } Triangle3D;

    localparam int CNT_W_DEFAULT = 16;

    localparam Points2D XMIN = -16'sd2048;
    localparam Points2D XMAX = 16'sd2047;
    localparam Points2D YMIN = -16'sd2048;
    localparam Points2D YMAX = 16'sd2047;
    localparam Points2D ZMIN = 16'sd0;
    localparam Points2D ZMAX = 16'sd16383;

    // Bounds are inclusive: a coordinate sitting exactly on MIN or MAX is kept.
    function automatic logic coord_oob(input Points2D c, input Points2D lo, input Points2D hi);
        return (c < lo) || (c > hi);
    endfunction

    function automatic logic vertex_oob(input Vertex3D v);
        return coord_oob(v.x, XMIN, XMAX) ||
               coord_oob(v.y, YMIN, YMAX) ||
               coord_oob(v.z, ZMIN, ZMAX);
    endfunction

    // A single stray coordinate anywhere in the triangle is enough to cull it.
    function automatic logic triangle_oob(input Triangle3D t);
        return vertex_oob(t.p) || vertex_oob(t.q) || vertex_oob(t.r);
    endfunction

endpackage

// File: rtl/tri_fifo.sv
// ----------------------------------------------------------------------------
// tri_fifo
// Circular buffer of Triangle3D entries feeding rasterizer setup.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   push      : write wr_data (accepted when not full, or when popping too)
//   pop       : remove the head entry (ignored when empty)
//   wr_data   : triangle to enqueue
//   rd_data   : head triangle, forced to zero when the buffer is empty
//   full      : all DEPTH entries occupied
//   empty     : no entries occupied
//   count     : occupied entries, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module tri_fifo
    import clip_cull_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  Triangle3D                wr_data,
    output Triangle3D                rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    Triangle3D        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    // A push into a full buffer is still fine when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping. Pointers are exactly PTR_W bits wide,
    // so incrementing past DEPTH-1 wraps to 0 without any compare. A push and
    // pop in the same cycle cancel out in the occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array. It is not reset: stale entries are never visible because
    // the read side is masked to zero whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/clip_cull_stage.sv
// ----------------------------------------------------------------------------
// clip_cull_stage
// Flags triangles with any vertex coordinate outside the clip volume, drops
// them, and queues surviving triangles in order for rasterizer setup.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   in_valid    : upstream triangle valid
//   in_ready    : stage can accept a triangle this cycle
//   tri_in      : incoming triangle
//   out_valid   : FIFO head valid
//   out_ready   : downstream accepts the head
//   tri_out     : FIFO head triangle (zero when empty)
//   fifo_count  : occupied FIFO entries
//   cull_count  : saturating count of dropped triangles since reset/clear
//   cnt_clear   : synchronous clear of cull_count (wins over a same-cycle cull)
// Build option: define CLIP_CULL_STATS_EN to build the cull counter; without
// it cull_count is tied to zero and cnt_clear is ignored.
// ----------------------------------------------------------------------------
module clip_cull_stage
    import clip_cull_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  Triangle3D                tri_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output Triangle3D                tri_out,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         cull_count,
    input  logic                     cnt_clear
);

    logic      s1_valid;
    Triangle3D s1_tri;
    logic      s1_oob;

    logic      in_fire;
    logic      out_fire;
    logic      fifo_full;
    logic      fifo_empty;
    logic      fifo_push;
    logic      s1_drains;
    logic      cull_event;

    assign out_valid  = !fifo_empty;
    assign out_fire   = out_valid && out_ready;
    assign in_fire    = in_valid && in_ready;

    // Culled triangles leave S1 unconditionally, so a full FIFO never stalls them.
    assign cull_event = s1_valid && s1_oob;
    assign fifo_push  = s1_valid && !s1_oob && (!fifo_full || out_fire);
    assign s1_drains  = cull_event || fifo_push;
    assign in_ready   = !s1_valid || s1_drains;

    // S1 register. A new triangle overwrites S1 whenever it is accepted, which
    // is only possible if S1 is empty or draining this cycle. The out-of-bounds
    // flag is computed once on entry and travels alongside the triangle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_tri   <= '0;
            s1_oob   <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_tri   <= tri_in;
            s1_oob   <= triangle_oob(tri_in);
        end else if (s1_drains) begin
            s1_valid <= 1'b0;
        end
    end

    tri_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .pop     (out_fire),
        .wr_data (s1_tri),
        .rd_data (tri_out),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

`ifdef CLIP_CULL_STATS_EN
    logic [CNT_W-1:0] cull_cnt_q;

    // Debug cull counter. Clear takes priority and swallows a coincident cull;
    // otherwise each cull adds one until the counter pins at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cull_cnt_q <= '0;
        end else if (cnt_clear) begin
            cull_cnt_q <= '0;
        end else if (cull_event && (cull_cnt_q != '1)) begin
            cull_cnt_q <= cull_cnt_q + 1'b1;
        end
    end

    assign cull_count = cull_cnt_q;
`else
    logic stats_unused;

    // Counter not built: report zero and deliberately sink the inputs that
    // would only have fed it.
    assign stats_unused = cnt_clear ^ cull_event;
    assign cull_count   = '0;
`endif

endmodule

// File: tb/tb_clip_cull_stage.sv
// ----------------------------------------------------------------------------
// tb_clip_cull_stage
// Scoreboard bench for clip_cull_stage: stimulus pushes expected survivors
// into a queue, an independent monitor pops and compares on each output
// transfer. Directed cases cover latency, bounds, backpressure, full-FIFO
// culls, mid-stream reset and counter saturation/clear; a random phase
// follows with random downstream backpressure.
// ----------------------------------------------------------------------------
module tb_clip_cull_stage;
    import clip_cull_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int CULL_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    Triangle3D        tri_in = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    Triangle3D        tri_out;
    logic [CW-1:0]    fifo_count;
    logic [CNT_W-1:0] cull_count;
    logic             cnt_clear = 1'b0;

    int        n_compared = 0;
    int        n_mismatched = 0;
    Triangle3D sb[$];
    int        model_culls = 0;
    bit        rand_ready_en = 1'b0;

    // Clip volume as plain integers, independent of the RTL encoding.
    int lo_bound[3] = '{-2048, -2048, 0};
    int hi_bound[3] = '{2047, 2047, 16383};

    always #5 clk = ~clk;

    clip_cull_stage #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tri_in     (tri_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .tri_out    (tri_out),
        .fifo_count (fifo_count),
        .cull_count (cull_count),
        .cnt_clear  (cnt_clear)
    );

    task automatic checkOutput(input string name, input logic [159:0] actual, input logic [159:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic Triangle3D make_tri(input int c[9]);
        Triangle3D t;
        t.p.x = Points2D'(c[0]);
        t.p.y = Points2D'(c[1]);
        t.p.z = Points2D'(c[2]);
        t.q.x = Points2D'(c[3]);
        t.q.y = Points2D'(c[4]);
        t.q.z = Points2D'(c[5]);
        t.r.x = Points2D'(c[6]);
        t.r.y = Points2D'(c[7]);
        t.r.z = Points2D'(c[8]);
        return t;
    endfunction

    function automatic bit model_oob(input int c[9]);
        for (int i = 0; i < 9; i++) begin
            if (c[i] < lo_bound[i % 3] || c[i] > hi_bound[i % 3]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [CNT_W-1:0] exp_cull();
`ifdef CLIP_CULL_STATS_EN
        return CNT_W'(model_culls);
`else
        return '0;
`endif
    endfunction

    // Random coordinates: boundary values are favoured; a "bad" triangle gets
    // exactly one coordinate pushed just outside its axis range.
    task automatic rand_coords(output int c[9], input bit bad);
        int k;
        int ax;
        for (int i = 0; i < 9; i++) begin
            ax = i % 3;
            case ($urandom_range(0, 5))
                0:       c[i] = lo_bound[ax];
                1:       c[i] = hi_bound[ax];
                default: c[i] = lo_bound[ax] + int'($urandom_range(0, hi_bound[ax] - lo_bound[ax]));
            endcase
        end
        if (bad) begin
            k  = int'($urandom_range(0, 8));
            ax = k % 3;
            if ($urandom_range(0, 1) == 0) c[k] = lo_bound[ax] - 1 - int'($urandom_range(0, 100));
            else                           c[k] = hi_bound[ax] + 1 + int'($urandom_range(0, 100));
        end
    endtask

    // Present one triangle (called just after a rising edge) and hold it until
    // accepted; the expected outcome is recorded at the moment of acceptance.
    task automatic applyStimulus(input int c[9]);
        int waited = 0;
        tri_in   = make_tri(c);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", in_ready, 1'b1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
        end
        if (model_oob(c)) begin
            if (model_culls < CULL_MAX) model_culls++;
        end else begin
            sb.push_back(make_tri(c));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic step_to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int waited = 0;
        @(negedge clk);
        while ((sb.size() != 0 || fifo_count != 0 || in_valid) && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        checkOutput({name, "_sb_empty"}, sb.size(), 0);
        checkOutput({name, "_fifo_count"}, fifo_count, 0);
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks that a
    // stalled head does not change while it waits.
    initial begin
        Triangle3D held;
        Triangle3D exp_tri;
        bit        held_v;
        held_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 1'b0;
                continue;
            end
            if (out_valid && held_v) checkOutput("tri_out_stable", tri_out, held);
            held_v = 1'b0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_output", out_valid, 1'b0);
                end else begin
                    exp_tri = sb.pop_front();
                    checkOutput("tri_out_data", tri_out, exp_tri);
                end
            end else if (out_valid) begin
                held   = tri_out;
                held_v = 1'b1;
            end
        end
    end

    // Random downstream backpressure, active only during the random phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready_en) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int c[9];
        int saved;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 1'b1);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_fifo_count", fifo_count, 0);
        checkOutput("rst_cull_count", cull_count, 0);
        checkOutput("rst_tri_out", tri_out, 0);

        // Single all-zero triangle: out_valid two cycles after acceptance.
        $display("[TB] single triangle latency");
        out_ready = 1'b1;
        step_to_drive();
        c = '{default: 0};
        applyStimulus(c);
        @(negedge clk);
        checkOutput("latency_n1_out_valid", out_valid, 1'b0);
        @(negedge clk);
        checkOutput("latency_n2_out_valid", out_valid, 1'b1);
        wait_drain("single");
        checkOutput("single_cull_count", cull_count, exp_cull());

        // q.y one above YMAX is culled; exact boundary values pass through.
        $display("[TB] bounds");
        step_to_drive();
        c = '{default: 0};
        c[4] = 2048;
        applyStimulus(c);
        c = '{-2048, 0, 16383, 2047, -2048, 0, 0, 2047, 16383};
        applyStimulus(c);
        c = '{0, 0, -1, 0, 0, 0, 0, 0, 0};
        applyStimulus(c);
        wait_drain("bounds");
        checkOutput("bounds_cull_count", cull_count, exp_cull());

        // Backpressure: four in the FIFO plus one held in S1.
        $display("[TB] backpressure");
        out_ready = 1'b0;
        step_to_drive();
        for (int i = 0; i < 5; i++) begin
            rand_coords(c, 1'b0);
            applyStimulus(c);
        end
        @(negedge clk);
        checkOutput("bp_fifo_count", fifo_count, DEPTH);
        checkOutput("bp_in_ready", in_ready, 1'b0);
        checkOutput("bp_out_valid", out_valid, 1'b1);
        step_to_drive();
        rand_coords(c, 1'b0);
        fork
            applyStimulus(c);
            begin
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("bp_stall_in_ready", in_ready, 1'b0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain("bp");

        // Culled triangle in S1 while the FIFO is full.
        $display("[TB] cull with full fifo");
        out_ready = 1'b0;
        step_to_drive();
        for (int i = 0; i < 4; i++) begin
            rand_coords(c, 1'b0);
            applyStimulus(c);
        end
        rand_coords(c, 1'b1);
        applyStimulus(c);
        @(negedge clk);
        checkOutput("fullcull_fifo_count", fifo_count, DEPTH);
        checkOutput("fullcull_in_ready", in_ready, 1'b1);
        @(negedge clk);
        checkOutput("fullcull_cull_count", cull_count, exp_cull());
        step_to_drive();
        out_ready = 1'b1;
        wait_drain("fullcull");

        // Asynchronous reset with three entries queued.
        $display("[TB] mid-stream reset");
        out_ready = 1'b0;
        step_to_drive();
        for (int i = 0; i < 3; i++) begin
            rand_coords(c, 1'b0);
            applyStimulus(c);
        end
        repeat (2) @(negedge clk);
        checkOutput("prerst_fifo_count", fifo_count, 3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        model_culls = 0;
        #1;
        checkOutput("async_rst_out_valid", out_valid, 1'b0);
        checkOutput("async_rst_fifo_count", fifo_count, 0);
        checkOutput("async_rst_in_ready", in_ready, 1'b1);
        checkOutput("async_rst_cull_count", cull_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_coords(c, 1'b0);
            applyStimulus(c);
        end
        wait_drain("postrst");

        // Counter saturation, then clear coincident with a cull.
        $display("[TB] cull counter");
        step_to_drive();
        for (int i = 0; i < CULL_MAX + 2; i++) begin
            rand_coords(c, 1'b1);
            applyStimulus(c);
        end
        repeat (3) @(negedge clk);
        checkOutput("sat_cull_count", cull_count, exp_cull());
        step_to_drive();
        rand_coords(c, 1'b1);
        applyStimulus(c);
        cnt_clear = 1'b1;
        @(posedge clk);
        #1;
        cnt_clear = 1'b0;
        model_culls = 0;
        @(negedge clk);
        checkOutput("clear_vs_cull", cull_count, exp_cull());
        step_to_drive();
        rand_coords(c, 1'b1);
        applyStimulus(c);
        repeat (2) @(negedge clk);
        checkOutput("after_clear_cull", cull_count, exp_cull());

        // Random traffic with random backpressure.
        $display("[TB] random phase");
        model_culls = 0;
        step_to_drive();
        cnt_clear = 1'b1;
        step_to_drive();
        cnt_clear = 1'b0;
        rand_ready_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rand_coords(c, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) step_to_drive();
            applyStimulus(c);
        end
        rand_ready_en = 1'b0;
        step_to_drive();
        out_ready = 1'b1;
        wait_drain("random");
        saved = model_culls;
        checkOutput("random_cull_count", cull_count, exp_cull());
        checkOutput("random_in_ready", in_ready, 1'b1);
        if (saved < 0) checkOutput("random_cull_model", saved, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/clip_cull_stage.md
# clip_cull_stage

Pipeline stage directly downstream of the triangle bounds check. It accepts transformed Triangle3D primitives on a valid/ready interface and flags any triangle with a vertex coordinate outside the clip volume. Flagged triangles are dropped, and surviving triangles are buffered in a small FIFO feeding the rasterizer setup stage. It also keeps an optional saturating count of culled triangles for debug.

## Interface
- DEPTH, 4, FIFO entries; power of two, minimum 2
- CNT_W, 16, width of cull counter
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous and active-high
- in_valid  in  1  upstream triangle valid
- in_ready  out  1  stage can accept this cycle
- tri_in  in  Triangle3D  p/q/r vertices, x/y/z each of package type Points2D
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accepts head
- tri_out  out  Triangle3D  FIFO head triangle
- fifo_count  out  $clog2(DEPTH)+1  occupied entries
- cull_count  out  CNT_W  triangles dropped since reset (see Configuration)
- cnt_clear  in  1  synchronous clear of cull_count

## Operation
- Input transfer happens when in_valid && in_ready.
- Stage S1 is one register: s1_valid, s1_tri, s1_oob.
- On transfer, s1_oob is computed from tri_in. It is the OR over all nine coordinates of (coord < MIN or coord > MAX) for the matching axis.
- Compares are signed. Bounds are inclusive, so a coordinate equal to MIN or MAX is in bounds.
- S1 drain rules:
  - s1_oob=1: the triangle is discarded unconditionally that cycle and cull_count increments.
  - s1_oob=0: the triangle is written to the FIFO if the FIFO is not full or a pop occurs the same cycle. Otherwise S1 holds.
- in_ready = !s1_valid || s1_drains. Back-to-back acceptance is sustained at one triangle per cycle.
- FIFO: circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy counter.
  - Simultaneous push and pop leaves the count unchanged and is legal when full.
  - Pop only when out_valid && out_ready.
- tri_out is driven from the head entry. It holds stable while out_valid && !out_ready.
- cull_count saturates at all-ones.
- cnt_clear has priority over an increment in the same cycle. The result is 0, and that cycle's cull is not counted.
- Triangle order is preserved. Dropped triangles leave no gap and no bubble downstream.

## Timing
- Reset values: in_ready=1, out_valid=0, fifo_count=0, cull_count=0, s1_valid=0, pointers=0. tri_out is 0 when empty.
- Reset mid-operation discards S1 and all FIFO contents immediately (asynchronous). No partial triangle is ever emitted.
- Latency with an empty FIFO: accept at cycle N, s1_valid at N+1, out_valid at N+2.
- Culled triangle: cull_count updates at N+2, with no output activity.
- Full FIFO with out_ready=0: S1 holds an in-bounds triangle and in_ready=0 from the next cycle.
- A culled triangle in S1 never stalls, even when the FIFO is full.
- Throughput: 1 triangle/cycle when out_ready=1.

## Configuration
- CLIP_CULL_STATS_EN defined: the cull counter and cnt_clear logic are built as described.
- Undefined: no counter register; cull_count is tied to 0 and cnt_clear is ignored. Datapath behaviour is otherwise identical.

## Structure
- Triangle3D, Points2D: shared defines package.
- XMIN/XMAX/YMIN/YMAX/ZMIN/ZMAX: clip defines header.
- CNT_W default: shared package constant.
- Sub-module tri_fifo (parameterised DEPTH, Triangle3D payload, push/pop/full/empty/count) holds the buffer. clip_cull_stage owns S1, the out-of-bounds compare and the counter.

## Test plan
- Single in-bounds triangle, all coordinates 0, out_ready=1 -> tri_out equals input at N+2, fifo_count returns to 0, cull_count=0.
- Triangle with q.y = YMAX+1 -> no out_valid ever; cull_count=1. Coordinates exactly at XMIN/XMAX/ZMAX -> passed through.
- out_ready=0, 6 in-bounds triangles streamed -> 4 in the FIFO plus 1 in S1, in_ready=0. Release out_ready -> all 5 drained in order, then the 6th is accepted.
- FIFO full while a culled triangle is in S1 -> it is dropped that cycle, in_ready stays 1, cull_count increments.
- Async rst asserted mid-stream with 3 entries queued -> out_valid=0 and fifo_count=0 immediately; post-reset input is processed normally.
- cull_count forced to 0xFFFF with a further cull -> stays 0xFFFF. cnt_clear coincident with a cull -> 0. Without CLIP_CULL_STATS_EN -> cull_count is always 0.
